// File: rtl/clk_div_monitor.sv
// Divided-clock health monitor: measures the period of a slow async clock
// in clk cycles and reports lock, mismatch and loss-of-edge events.
module clk_div_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 8,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             err,
    output logic             timeout
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LO = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
    localparam int HI = EXP_PERIOD + TOL;

    localparam logic [CNT_W-1:0] LO_C  = CNT_W'(LO);
    localparam logic [CNT_W-1:0] HI_C  = CNT_W'(HI);
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MAX_C = '1;
    localparam logic [MW-1:0]    LCK_C = MW'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        ACQ,
        LOCKED
    } state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] cnt;
    logic [MW-1:0]    match;
    logic [MW-1:0]    match_nx;
    logic             rise;
    logic             is_match;
    logic             tmo;

    assign rise     = s2 & ~s3;
    assign is_match = (cnt >= LO_C) && (cnt <= HI_C);
    assign tmo      = ~rise && (cnt == TMO_C);
    assign match_nx = match + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            cnt        <= '0;
            match      <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            s1         <= sig_in;
            s2         <= s1;
            s3         <= s2;
            period_vld <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
            if (!en || state == IDLE) begin
                cnt    <= '0;
                match  <= '0;
                locked <= 1'b0;
                state  <= en ? ARM : IDLE;
            end else begin
                if (rise)
                    cnt <= CNT_W'(1);
                else if (cnt != MAX_C)
                    cnt <= cnt + 1'b1;
                // rise has priority over timeout when both land together
                case (state)
                    ARM: begin
                        if (rise)
                            state <= ACQ;
                        else if (tmo)
                            timeout <= 1'b1;
                    end
                    ACQ: begin
                        if (rise) begin
                            period     <= cnt;
                            period_vld <= 1'b1;
                            if (is_match) begin
                                match <= match_nx;
                                if (match_nx == LCK_C) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                match <= '0;
                            end
                        end else if (tmo) begin
                            timeout <= 1'b1;
                            match   <= '0;
                            state   <= ARM;
                        end
                    end
                    LOCKED: begin
                        if (rise) begin
                            period     <= cnt;
                            period_vld <= 1'b1;
                            if (!is_match) begin
                                err    <= 1'b1;
                                locked <= 1'b0;
                                match  <= '0;
                                state  <= ACQ;
                            end
                        end else if (tmo) begin
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                            match   <= '0;
                            state   <= ARM;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: lock, error, timeout, reset,
// enable and tolerance scenarios with hand-computed expectations.
module tb_clk_div_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        sig_a = 1'b0;
    logic        sig_b = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] per_a, per_b;
    logic        vld_a, vld_b, lk_a, lk_b;
    logic        er_a, er_b, to_a, to_b;

    logic [15:0] per_m;
    logic        vld_m, lk_m, er_m, to_m;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_vld = 0;
    int gap = 0;
    int n_err = 0;
    int n_to = 0;
    int perq[$];
    bit lkq[$];
    bit erq[$];

    always #5 clk = ~clk;

    clk_div_monitor dut_a (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_a),
        .period(per_a), .period_vld(vld_a), .locked(lk_a),
        .err(er_a), .timeout(to_a)
    );

    clk_div_monitor #(.TOL(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_b),
        .period(per_b), .period_vld(vld_b), .locked(lk_b),
        .err(er_b), .timeout(to_b)
    );

    assign per_m = sel ? per_b : per_a;
    assign vld_m = sel ? vld_b : vld_a;
    assign lk_m  = sel ? lk_b  : lk_a;
    assign er_m  = sel ? er_b  : er_a;
    assign to_m  = sel ? to_b  : to_a;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (vld_m) begin
            perq.push_back(int'(per_m));
            lkq.push_back(lk_m);
            erq.push_back(er_m);
            last_vld = cyc;
        end
        if (er_m) n_err++;
        if (to_m) begin
            n_to++;
            gap = cyc - last_vld;
        end
    endtask

    task automatic drv(input bit v);
        if (sel) sig_b = v;
        else sig_a = v;
    endtask

    task automatic per(input int hi, input int lo);
        repeat (hi) begin drv(1'b1); tick(); end
        repeat (lo) begin drv(1'b0); tick(); end
    endtask

    task automatic clr();
        perq.delete();
        lkq.delete();
        erq.delete();
        n_err = 0;
        n_to  = 0;
    endtask

    task automatic lock_seq(input string t);
        clr();
        repeat (6) per(4, 4);
        check({t, "_nvld"}, perq.size(), 5);
        check({t, "_per0"}, perq[0], 8);
        check({t, "_per4"}, perq[4], 8);
        check({t, "_lk2"}, lkq[2], 0);
        check({t, "_lk3"}, lkq[3], 1);
        check({t, "_lk4"}, lkq[4], 1);
        check({t, "_nerr"}, n_err, 0);
        check({t, "_nto"}, n_to, 0);
    endtask

    initial begin
        // test 1: reset state then lock on clk/8
        tick();
        tick();
        check("rst_period", per_a, 0);
        check("rst_locked", lk_a, 0);
        check("rst_vld", vld_a, 0);
        rst = 1'b1;
        en  = 1'b1;
        tick();
        lock_seq("t1");

        // test 2: one stretched period of 9
        clr();
        per(5, 4);
        repeat (5) per(4, 4);
        check("t2_nvld", perq.size(), 6);
        check("t2_per0", perq[0], 8);
        check("t2_per1", perq[1], 9);
        check("t2_err1", erq[1], 1);
        check("t2_lk0", lkq[0], 1);
        check("t2_lk1", lkq[1], 0);
        check("t2_lk4", lkq[4], 0);
        check("t2_lk5", lkq[5], 1);
        check("t2_nerr", n_err, 1);

        // test 3: stopped clock times out 64 cycles after last rise
        clr();
        drv(1'b0);
        repeat (70) tick();
        check("t3_nto", n_to, 1);
        check("t3_gap", gap, 64);
        check("t3_locked", lk_a, 0);
        lock_seq("t3");

        // test 4: reset mid-period
        per(4, 2);
        rst = 1'b0;
        tick();
        check("t4_period", per_a, 0);
        check("t4_locked", lk_a, 0);
        check("t4_vld", vld_a, 0);
        check("t4_err", er_a, 0);
        check("t4_to", to_a, 0);
        rst = 1'b1;
        lock_seq("t4");

        // test 5: disable while locked
        en = 1'b0;
        tick();
        check("t5_locked", lk_a, 0);
        clr();
        repeat (3) per(4, 4);
        repeat (70) tick();
        check("t5_nvld", perq.size(), 0);
        check("t5_nerr", n_err, 0);
        check("t5_nto", n_to, 0);
        en = 1'b1;
        tick();
        lock_seq("t5");

        // test 6: TOL=1 instance
        rst = 1'b0;
        tick();
        rst = 1'b1;
        sel = 1'b1;
        tick();
        clr();
        per(4, 3);
        per(4, 5);
        per(4, 4);
        per(4, 3);
        per(5, 5);
        per(4, 4);
        check("t6_nvld", perq.size(), 5);
        check("t6_per0", perq[0], 7);
        check("t6_per1", perq[1], 9);
        check("t6_per3", perq[3], 7);
        check("t6_per4", perq[4], 10);
        check("t6_lk2", lkq[2], 0);
        check("t6_lk3", lkq[3], 1);
        check("t6_lk4", lkq[4], 0);
        check("t6_err3", erq[3], 0);
        check("t6_err4", erq[4], 1);
        check("t6_nto", n_to, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
